// File: rtl/latch_write_arbiter_pkg.sv
// Shared types and sizing helpers for the latch write arbiter.
//   state_t  : sequencer states (IDLE, SETUP, PULSE, HOLD)
//   aw_of    : address/index width for a count of items, never below 1
//   cnt_w_of : phase down-counter width for given SETUP/PULSE/HOLD lengths
//   CNT_W    : counter width for the default phase lengths (1/2/1)
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int aw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w_of(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_w_of(1, 2, 1);

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Requester / latch-bank bundle for the latch write arbiter.
//   req, reqAddr, reqData    : requester side, slice i belongs to requester i
//   gnt, err                 : one-cycle completion pulses back to requesters
//   latchEn, latchD          : one-hot enables and shared data to the latch bank
//   busy                     : sequencer not idle
// modport slave  : the arbiter
// modport master : the requesting logic / environment
interface latch_write_arbiter_if
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int N_ENTRY = 4,
    parameter int AW      = aw_of(N_ENTRY)
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ*AW-1:0]    reqAddr;
    logic [N_REQ*WIDTH-1:0] reqData;
    logic [N_REQ-1:0]       gnt;
    logic                   err;
    logic [N_ENTRY-1:0]     latchEn;
    logic [WIDTH-1:0]       latchD;
    logic                   busy;

    modport slave (
        input  req, reqAddr, reqData,
        output gnt, err, latchEn, latchD, busy
    );

    modport master (
        output req, reqAddr, reqData,
        input  gnt, err, latchEn, latchD, busy
    );

endinterface

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req         : request vector
//   last_winner : index of the previous winner; search starts one above it
//   gnt_oh      : one-hot selected requester (0 when nothing requested)
//   gnt_idx     : index of the selected requester
//   gnt_vld     : at least one request present
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = aw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_winner,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    logic [IW-1:0] cand;

    // Walk k = 1..N_REQ so the previous winner is considered last.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_winner) + k) % N_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin write sequencer for a shared bank of level-sensitive latches.
// Each accepted write runs SETUP -> PULSE -> HOLD so latchD is stable around
// the enable window.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : latch_write_arbiter_if.slave (requests in, gnt/err/latch bank out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; accepts the round-robin winner and captures addr/data
// SETUP | data driven, enables low, SETUP_CYC cycles
// PULSE | latchEn[addr] high (unless addr out of range), PULSE_CYC cycles
// HOLD  | data still driven, enables low, HOLD_CYC cycles; gnt in last one
module latch_write_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int N_ENTRY   = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int AW        = aw_of(N_ENTRY)
) (
    input  logic clk,
    input  logic rst_n,
    latch_write_arbiter_if.slave bus
);

    localparam int IW = aw_of(N_REQ);
    localparam int CW = cnt_w_of(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              accept;

    logic [N_REQ-1:0]  arb_oh;
    logic [IW-1:0]     arb_idx;
    logic              arb_vld;

    logic [IW-1:0]     last_q;
    logic [N_REQ-1:0]  win_oh_q;
    logic [AW-1:0]     addr_q;
    logic [WIDTH-1:0]  data_q;

    logic [N_REQ-1:0]   gnt_d,   gnt_q;
    logic               err_d,   err_q;
    logic [N_ENTRY-1:0] en_d,    en_q;
    logic               busy_d,  busy_q;
    logic               addr_ok;
    logic               last_hold;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req         (bus.req),
        .last_winner (last_q),
        .gnt_oh      (arb_oh),
        .gnt_idx     (arb_idx),
        .gnt_vld     (arb_vld)
    );

    // State register and phase down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: counter is loaded with length-1 on entry, phase ends at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state they belong to. addr_q is already stable by
    // the time PULSE is entered, since capture happens on IDLE->SETUP.
    always_comb begin
        en_d      = '0;
        addr_ok   = (int'(addr_q) < N_ENTRY);
        last_hold = (state_d == HOLD) && (cnt_d == '0);
        for (int e = 0; e < N_ENTRY; e++) begin
            en_d[e] = (state_d == PULSE) && (addr_q == AW'(e));
        end
        gnt_d  = last_hold ? win_oh_q : '0;
        err_d  = last_hold && !addr_ok;
        busy_d = (state_d != IDLE);
    end

    // Capture registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= IW'(N_REQ - 1);
            win_oh_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            en_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (accept) begin
                last_q   <= arb_idx;
                win_oh_q <= arb_oh;
                addr_q   <= bus.reqAddr[int'(arb_idx)*AW +: AW];
                data_q   <= bus.reqData[int'(arb_idx)*WIDTH +: WIDTH];
            end
            gnt_q  <= gnt_d;
            err_q  <= err_d;
            en_q   <= en_d;
            busy_q <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.err     = err_q;
    assign bus.latchEn = en_q;
    assign bus.latchD  = data_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
module tb_latch_write_arbiter;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    // DUT A: default timing, 3-bit addresses so out-of-range targets exist.
    latch_write_arbiter_if #(.N_REQ(4), .WIDTH(8), .N_ENTRY(4), .AW(3)) ifa ();
    // DUT B: SETUP=2, PULSE=1, HOLD=3, default 2-bit addresses.
    latch_write_arbiter_if #(.N_REQ(4), .WIDTH(8), .N_ENTRY(4)) ifb ();

    latch_write_arbiter #(
        .N_REQ(4), .WIDTH(8), .N_ENTRY(4),
        .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .AW(3)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    latch_write_arbiter #(
        .N_REQ(4), .WIDTH(8), .N_ENTRY(4),
        .SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       idx;
        int       addr;
        logic [7:0] data;
        bit       err;
        int       gap;
    } exp_t;

    exp_t sb[$];

    // Hand-computed per-cycle tables, index k-1 for the negedge after edge k.
    int t1_en   [5] = '{0, 4, 4, 0, 0};
    int t1_gnt  [5] = '{0, 0, 0, 1, 0};
    int t1_busy [5] = '{1, 1, 1, 1, 0};
    int t6_en   [8] = '{0, 0, 2, 0, 0, 0, 0, 0};
    int t6_gnt  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int t6_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic push(input int idx, input int addr, input logic [7:0] data,
                        input bit err, input int gap);
        exp_t e;
        e.idx = idx; e.addr = addr; e.data = data; e.err = err; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [2:0] a, input logic [7:0] d);
        ifa.reqAddr[i*3 +: 3] = a;
        ifa.reqData[i*8 +: 8] = d;
    endtask

    task automatic clear_inputs();
        ifa.req = '0; ifa.reqAddr = '0; ifa.reqData = '0;
        ifb.req = '0; ifb.reqAddr = '0; ifb.reqData = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait until requester `who` of DUT A has been granted `n` times.
    task automatic wait_gnt_a(input int who, input int n, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (ifa.gnt[who]) seen++;
            if (seen == n) break;
        end
        chk(name, seen, n);
    endtask

    // Monitor: accumulates what DUT A shows on the latch side during a write
    // and checks it against the scoreboard entry when gnt appears.
    int         p_cnt;
    logic [3:0] p_en;
    logic [7:0] p_d;
    logic [7:0] seq_d;
    bit         d_chg;
    bit         busy_prev;
    int         last_gnt_cyc;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_cnt = 0; p_en = '0; p_d = '0; seq_d = '0; d_chg = 0; busy_prev = 0;
        end else begin
            if (ifa.latchEn != '0) begin
                p_cnt++;
                p_en = ifa.latchEn;
                p_d  = ifa.latchD;
            end
            if (ifa.busy && !busy_prev) begin
                seq_d = ifa.latchD;
                d_chg = 0;
            end else if (ifa.busy && ifa.latchD !== seq_d) begin
                d_chg = 1;
            end
            busy_prev = ifa.busy;
            if (ifa.gnt != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", 32'(ifa.gnt), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_gnt",   32'(ifa.gnt), 32'(1 << e.idx));
                    chk("sb_err",   32'(ifa.err), 32'(e.err));
                    chk("sb_en",    32'(p_en),   e.err ? 32'h0 : 32'(1 << e.addr));
                    chk("sb_width", 32'(p_cnt),  e.err ? 32'h0 : 32'd2);
                    if (!e.err) chk("sb_pulse_d", 32'(p_d), 32'(e.data));
                    chk("sb_seq_d", 32'(seq_d), 32'(e.data));
                    chk("sb_d_stable", 32'(d_chg), 32'h0);
                    if (e.gap != 0) chk("sb_gap", cyc - last_gnt_cyc, e.gap);
                end
                last_gnt_cyc = cyc;
                p_cnt = 0; p_en = '0; p_d = '0;
            end else if (ifa.err) begin
                chk("stray_err", 32'(ifa.err), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset values
        tick();
        tick();
        chk("rst_gnt",     32'(ifa.gnt),     32'h0);
        chk("rst_err",     32'(ifa.err),     32'h0);
        chk("rst_latchEn", 32'(ifa.latchEn), 32'h0);
        chk("rst_latchD",  32'(ifa.latchD),  32'h0);
        chk("rst_busy",    32'(ifa.busy),    32'h0);
        rst_n = 1'b1;
        tick();

        // Test 1: single write, requester 0, addr 2, data A5
        set_a(0, 3'd2, 8'hA5);
        ifa.req = 4'b0001;
        push(0, 2, 8'hA5, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            if (k == 1) begin
                #1;
                ifa.req = '0;
            end
            @(negedge clk);
            chk($sformatf("t1_latchD_%0d", k),  32'(ifa.latchD),  32'hA5);
            chk($sformatf("t1_latchEn_%0d", k), 32'(ifa.latchEn), 32'(t1_en[k-1]));
            chk($sformatf("t1_gnt_%0d", k),     32'(ifa.gnt),     32'(t1_gnt[k-1]));
            chk($sformatf("t1_busy_%0d", k),    32'(ifa.busy),    32'(t1_busy[k-1]));
        end
        tick();

        // Test 2: all four held, order 0,1,2,3,0 with 5-cycle spacing
        do_reset();
        set_a(0, 3'd3, 8'h10);
        set_a(1, 3'd2, 8'h21);
        set_a(2, 3'd1, 8'h32);
        set_a(3, 3'd0, 8'h43);
        push(0, 3, 8'h10, 0, 0);
        push(1, 2, 8'h21, 0, 5);
        push(2, 1, 8'h32, 0, 5);
        push(3, 0, 8'h43, 0, 5);
        push(0, 3, 8'h10, 0, 5);
        ifa.req = 4'b1111;
        wait_gnt_a(0, 2, "t2_wait_gnt");
        ifa.req = '0;
        repeat (3) tick();

        // Test 3: requester 1 data changes to FF during PULSE
        set_a(1, 3'd1, 8'h11);
        ifa.req = 4'b0010;
        push(1, 1, 8'h11, 0, 0);
        tick();
        ifa.req = '0;
        tick();
        tick();
        ifa.reqData[15:8] = 8'hFF;
        tick();
        chk("t3_hold_latchD", 32'(ifa.latchD), 32'h11);
        repeat (3) tick();

        // Test 4: out-of-range address, then a normal write
        set_a(2, 3'd5, 8'h5A);
        ifa.req = 4'b0100;
        push(2, 5, 8'h5A, 1, 0);
        tick();
        ifa.req = '0;
        repeat (5) tick();
        set_a(3, 3'd3, 8'hC3);
        ifa.req = 4'b1000;
        push(3, 3, 8'hC3, 0, 0);
        tick();
        ifa.req = '0;
        repeat (5) tick();

        // Test 5: reset in first PULSE cycle, then requester 0 wins first
        set_a(2, 3'd1, 8'h77);
        ifa.req = 4'b0100;
        tick();
        ifa.req = '0;
        tick();
        chk("t5_pulse_en", 32'(ifa.latchEn), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_latchEn", 32'(ifa.latchEn), 32'h0);
        chk("t5_rst_gnt",     32'(ifa.gnt),     32'h0);
        chk("t5_rst_busy",    32'(ifa.busy),    32'h0);
        chk("t5_rst_latchD",  32'(ifa.latchD),  32'h0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_a(0, 3'd0, 8'h01);
        set_a(2, 3'd3, 8'h02);
        push(0, 0, 8'h01, 0, 0);
        push(2, 3, 8'h02, 0, 5);
        ifa.req = 4'b0101;
        wait_gnt_a(2, 1, "t5_wait_gnt");
        ifa.req = '0;
        repeat (3) tick();

        // Test 6: DUT B, SETUP=2 PULSE=1 HOLD=3, requester 0 addr 1 data 3C
        ifb.reqAddr[1:0] = 2'd1;
        ifb.reqData[7:0] = 8'h3C;
        ifb.req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            if (k == 1) begin
                #1;
                ifb.req = '0;
            end
            @(negedge clk);
            chk($sformatf("t6_latchD_%0d", k),  32'(ifb.latchD),  32'h3C);
            chk($sformatf("t6_latchEn_%0d", k), 32'(ifb.latchEn), 32'(t6_en[k-1]));
            chk($sformatf("t6_gnt_%0d", k),     32'(ifb.gnt),     32'(t6_gnt[k-1]));
            chk($sformatf("t6_busy_%0d", k),    32'(ifb.busy),    32'(t6_busy[k-1]));
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
